// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with refresh prescaler, tear-free
// double-buffered value load, leading-zero blanking, anti-ghost blanking and selectable polarity.
module seg7_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [4*N_DIGITS-1:0]       value_i,
    input  logic [N_DIGITS-1:0]         dp_in_i,
    input  logic                        load_i,
    input  logic                        blank_lz_i,
    input  logic                        enable_i,
    output logic [6:0]                  seg_o,
    output logic                        dp_o,
    output logic [N_DIGITS-1:0]         an_o,
    output logic [$clog2(N_DIGITS)-1:0] scan_idx_o,
    output logic                        frame_start_o
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [PRE_W-1:0]      prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_start_q, frame_start_d;

    logic                  slot_wrap;
    logic                  frame_wrap;
    logic [N_DIGITS-1:0]   zero_above;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [6:0]            seg_act;
    logic                  dp_act;
    logic [N_DIGITS-1:0]   an_act;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h77;
            4'hB: return 7'h1F;
            4'hC: return 7'h4E;
            4'hD: return 7'h3D;
            4'hE: return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    // Scan timing and double buffer; shadow only changes at the frame wrap so a frame never tears.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        prescaler_d   = prescaler_q + PRE_W'(1);
        scan_idx_d    = scan_idx_q;
        pend_val_d    = pend_val_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;

        slot_wrap     = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
        frame_wrap    = slot_wrap && (scan_idx_q == IDX_W'(N_DIGITS - 1));
        frame_start_d = frame_wrap;

        if (slot_wrap) begin
            prescaler_d = '0;
            scan_idx_d  = frame_wrap ? '0 : scan_idx_q + IDX_W'(1);
        end

        if (frame_wrap) begin
            if (load_i) begin
                shadow_val_d = value_i;
                shadow_dp_d  = dp_in_i;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end else if (load_i) begin
            pend_val_d   = value_i;
            pend_dp_d    = dp_in_i;
            pend_valid_d = 1'b1;
        end
    end

    // zero_above[k] is set when shadow nibbles k..N_DIGITS-1 are all zero.
    always_comb begin
        zero_above = '0;
        zero_above[N_DIGITS-1] = (shadow_val_q[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int k = N_DIGITS - 2; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] && (shadow_val_q[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib   = shadow_val_q[{scan_idx_q, 2'b00} +: 4];
        cur_blank = blank_lz_i && (scan_idx_q != '0) && zero_above[scan_idx_q];
        seg_act   = '0;
        dp_act    = 1'b0;
        an_act    = '0;

        if (enable_i) begin
            seg_act = cur_blank ? 7'h00 : hex_glyph(cur_nib);
            dp_act  = shadow_dp_q[scan_idx_q];
            // Anodes stay dark at the start of a slot while segments settle to the new glyph.
            if (prescaler_q >= PRE_W'(BLANK_CYCLES)) begin
                an_act[scan_idx_q] = 1'b1;
            end
        end

        seg_d = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_act  : dp_act;
        an_d  = AN_ACTIVE_LOW  ? ~an_act  : an_act;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
        if (rst_i) begin
            prescaler_q   <= '0;
            scan_idx_q    <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            scan_idx_q    <= scan_idx_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign an_o          = an_q;
    assign scan_idx_o    = scan_idx_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: table-driven display vectors through a
// scoreboard queue, plus hand-written tear-free load, enable and mid-frame reset sequences.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  scan_idx;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS      (N),
        .REFRESH_DIV   (DIV),
        .BLANK_CYCLES  (BLANK),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .value_i      (value),
        .dp_in_i      (dp_in),
        .load_i       (load),
        .blank_lz_i   (blank_lz),
        .enable_i     (enable),
        .seg_o        (seg),
        .dp_o         (dp),
        .an_o         (an),
        .scan_idx_o   (scan_idx),
        .frame_start_o(frame_start)
    );

    // Active-high glyph per digit (7'h00 = blanked) and expected lit decimal points.
    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic            blank_lz;
        logic [3:0][6:0] glyph;
        logic [3:0]      dp_exp;
    } vec_t;

    // Pin-level expectation for one sampled cycle.
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each slot is sampled twice: first cycle (anodes dark, glyph present) and second (digit lit).
    task automatic push_frame(input logic [3:0][6:0] g, input logic [3:0] dpm);
        logic [3:0] an_sel;
        for (int k = 0; k < N; k++) begin
            an_sel = 4'b0001 << k;
            sb_q.push_back('{an: 4'hF, seg: ~g[k], dp: ~dpm[k]});
            sb_q.push_back('{an: ~an_sel, seg: ~g[k], dp: ~dpm[k]});
        end
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (frame_start !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    // Walks one frame from its frame_start; optionally loads new_val while scan_idx is 2.
    task automatic check_frame(input logic do_load, input logic [15:0] new_val);
        exp_t e;
        wait_frame_start();
        check("frame_idx0", {30'd0, scan_idx}, 32'd0);
        for (int c = 1; c < FRAME; c++) begin
            @(negedge clk);
            check("frame_start_low", {31'd0, frame_start}, 32'd0);
            if (c % DIV == 1 || c % DIV == 2) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("an_d%0d_c%0d", c / DIV, c), {28'd0, an}, {28'd0, e.an});
                    check($sformatf("seg_d%0d_c%0d", c / DIV, c), {25'd0, seg}, {25'd0, e.seg});
                    check($sformatf("dp_d%0d_c%0d", c / DIV, c), {31'd0, dp}, {31'd0, e.dp});
                end
            end
            if (do_load && c == 9) begin
                check("load_at_idx2", {30'd0, scan_idx}, 32'd2);
                value = new_val;
                load  = 1'b1;
            end
            if (do_load && c == 10) load = 1'b0;
        end
    endtask

    task automatic apply_vector(input vec_t v);
        value    = v.value;
        dp_in    = v.dp_in;
        blank_lz = v.blank_lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        push_frame(v.glyph, v.dp_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h30, 7'h6D, 7'h77, 7'h47}, 4'b0000};
        vecs[1] = '{16'h0040, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h33, 7'h7E}, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000};
        vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000};
        vecs[4] = '{16'h0040, 4'b0100, 1'b1, {7'h00, 7'h00, 7'h33, 7'h7E}, 4'b0100};
        vecs[5] = '{16'h3B8C, 4'b1001, 1'b0, {7'h79, 7'h1F, 7'h7F, 7'h4E}, 4'b1001};
        vecs[6] = '{16'h0D05, 4'b0000, 1'b1, {7'h00, 7'h3D, 7'h7E, 7'h5B}, 4'b0000};
        vecs[7] = '{16'h6E97, 4'b1111, 1'b1, {7'h5F, 7'h4F, 7'h7B, 7'h70}, 4'b1111};

        rst = 1'b1; value = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_idx", {30'd0, scan_idx}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;

        // Frame period: consecutive frame_start pulses are N*DIV cycles apart.
        wait_frame_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 64);
        check("frame_period", n, FRAME);

        for (int i = 0; i < 8; i++) begin
            apply_vector(vecs[i]);
            check_frame(1'b0, 16'h0000);
        end

        // Tear-free load: 2222 loaded at scan_idx 2 must not reach digits 2,3 of that frame.
        value = 16'h1111; dp_in = 4'b0000; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_frame({4{7'h30}}, 4'b0000);
        check_frame(1'b0, 16'h0000);
        push_frame({4{7'h30}}, 4'b0000);
        push_frame({4{7'h6D}}, 4'b0000);
        check_frame(1'b1, 16'h2222);
        check_frame(1'b0, 16'h0000);

        // Enable dropped mid-slot, counters keep running, resumes at the correct digit.
        wait_frame_start();
        repeat (6) @(negedge clk);
        check("en_before_an", {28'd0, an}, 32'hD);
        enable = 1'b0;
        @(negedge clk);
        check("en_off_an", {28'd0, an}, 32'hF);
        check("en_off_seg", {25'd0, seg}, 32'h7F);
        check("en_off_dp", {31'd0, dp}, 32'd1);
        wait_frame_start();
        check("en_off_fs_an", {28'd0, an}, 32'hF);
        check("en_off_fs_seg", {25'd0, seg}, 32'h7F);
        enable = 1'b1;
        @(negedge clk);
        check("en_on_blank_an", {28'd0, an}, 32'hF);
        check("en_on_seg", {25'd0, seg}, {25'd0, ~7'h6D});
        @(negedge clk);
        check("en_on_an", {28'd0, an}, 32'hE);
        check("en_on_idx", {30'd0, scan_idx}, 32'd0);

        // Reset during scan_idx 3 with a pending load: scan aborts and the pending value is lost.
        repeat (10) @(negedge clk);
        check("rst_mid_idx3", {30'd0, scan_idx}, 32'd3);
        value = 16'h5555; load = 1'b1;
        @(negedge clk);
        load = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstm_an", {28'd0, an}, 32'hF);
        check("rstm_seg", {25'd0, seg}, 32'h7F);
        check("rstm_dp", {31'd0, dp}, 32'd1);
        check("rstm_idx", {30'd0, scan_idx}, 32'd0);
        check("rstm_fs", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rstm_d0_an", {28'd0, an}, 32'hE);
        check("rstm_d0_seg", {25'd0, seg}, {25'd0, ~7'h7E});
        push_frame({4{7'h7E}}, 4'b0000);
        check_frame(1'b0, 16'h0000);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display; successor to the single-digit hex decoder.
- Adds parametrised digit count, refresh prescaler, tear-free double-buffered value load, per-digit decimal point, leading-zero blanking, anti-ghost blanking and selectable output polarity.
- Sits between core logic (hex value plus DP mask) and the board segment/anode pins.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 2, cycles at start of each slot with all anodes inactive (0 = off)
SEG_ACTIVE_LOW, 1, 1: segment/dp outputs driven 0 = lit
AN_ACTIVE_LOW, 1, 1: anode outputs driven 0 = selected

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
value  in  4*N_DIGITS  hex nibbles; nibble i = digit i, digit 0 rightmost
dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
load  in  1  capture value/dp_in into pending buffer
blank_lz  in  1  1: suppress leading zeros
enable  in  1  0: display dark
seg  out  7  segments {A,B,C,D,E,F,G}, seg[6]=A
dp  out  1  decimal point
an  out  N_DIGITS  one-hot digit select
scan_idx  out  $clog2(N_DIGITS)  digit currently owning the slot
frame_start  out  1  one-cycle pulse when scan_idx wraps to 0

Behaviour:
- Reset: prescaler=0, scan_idx=0, pending/shadow value=0, dp=0, pend_valid=0; seg, dp, an all at inactive level; frame_start=0. Reset mid-frame aborts the scan immediately.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle scan_idx advances (N_DIGITS-1 -> 0).
- frame_start=1 on the cycle scan_idx becomes 0.
- Double buffer:
  - load=1 writes pending buffer and sets pend_valid; the last load before a boundary wins.
  - At a frame boundary (scan_idx wrap) with pend_valid=1: shadow <= pending, pend_valid <= 0.
  - load on the boundary cycle itself goes directly to shadow.
  - The displayed frame never mixes old and new digits.
- Glyphs (active-high, ABCDEFG), 0..F: 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
- Leading-zero blanking (blank_lz=1): digit k is blanked if shadow nibbles k..N_DIGITS-1 are all 0. Digit 0 is never blanked. Blanked digit: seg inactive, dp still follows dp_in. Evaluated on shadow.
- Anti-ghost: while prescaler < BLANK_CYCLES, an is all inactive. seg/dp already carry the new digit's glyph.
- enable=0: an all inactive, seg/dp inactive, counters keep running, buffer logic unaffected.
- Outputs registered. seg/dp/an reflect scan_idx and shadow one cycle after either changes.
- Polarity: active-low parameters invert the final registered outputs.

Test Plan:
1. N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, both polarities low. Release rst, load value=16'h12AF, dp_in=0 -> each 16-cycle frame shows an = E,D,B,7 with seg = ~47 (F), ~77 (A), ~6D (2), ~30 (1); first cycle of each slot an=F; frame_start pulses every 16 cycles.
2. Tear-free load: value 16'h1111 displayed; load 16'h2222 mid-frame at scan_idx=2 -> digits 2,3 of the current frame still show 1; whole next frame shows 2.
3. Leading zeros: value 16'h0040, blank_lz=1 -> digits 3,2 segments inactive, digit 1 shows 4 (33), digit 0 shows 0 (7E). value 16'h0000 -> only digit 0 lit, showing 0. blank_lz=0 -> all four digits show their glyph.
4. dp_in=4'b0100 with digit 2 blanked -> during slot 2, seg inactive and dp active.
5. enable=0 mid-slot -> an and seg inactive on the next cycle; frame_start keeps pulsing; enable=1 resumes at the correct scan_idx.
6. Assert rst during scan_idx=3 with pend_valid=1 -> next cycle: an/seg inactive, scan_idx=0, pending discarded (shadow=0, digit 0 shows 7E after rst).
